// File: rtl/cla_bist_ctrl.sv
// Built-in self-test controller for a 16-bit adder on the A/B/Cin -> Sum/Cout
// interface: four directed corner vectors followed by LFSR pseudo-random
// vectors, each checked against an internal WIDTH+1-bit reference sum.
module cla_bist_ctrl #(
  parameter int unsigned       WIDTH       = 16,
  parameter int unsigned       NUM_VECTORS = 65535,
  parameter logic [WIDTH-1:0]  SEED_A      = 16'hACE1,
  parameter logic [WIDTH-1:0]  SEED_B      = 16'h1D2C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] dut_A,
  output logic [WIDTH-1:0] dut_B,
  output logic             dut_Cin,
  input  logic [WIDTH-1:0] dut_Sum,
  input  logic             dut_Cout,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [16:0]      vec_count,
  output logic [WIDTH:0]   err_exp,
  output logic [WIDTH:0]   err_got
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam logic [WIDTH-1:0] POLY = WIDTH'(16'hB400);
  localparam logic [16:0]      LAST = 17'(NUM_VECTORS);

  state_t           state, state_next;
  logic [WIDTH-1:0] lfsr_a, lfsr_b;
  logic [WIDTH-1:0] vec_a, vec_b;
  logic             vec_cin;
  logic [WIDTH:0]   exp_sum;
  logic [WIDTH:0]   got_sum;
  logic             match;
  logic             directed;
  logic [16:0]      vec_count_inc;
  logic             last_vec;

  // Galois LFSR step, right shift, feedback taps applied when bit 0 falls out.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    lfsr_step = (v >> 1) ^ (v[0] ? POLY : '0);
  endfunction

  // Reference sum, comparison and run-progress decode.
  always_comb begin
    exp_sum       = {1'b0, dut_A} + {1'b0, dut_B} + {{WIDTH{1'b0}}, dut_Cin};
    got_sum       = {dut_Cout, dut_Sum};
    match         = (exp_sum == got_sum);
    vec_count_inc = vec_count + 17'd1;
    last_vec      = (vec_count_inc == LAST);
    // The vector index k equals vec_count+1 while running, so the first four
    // vectors are the directed ones exactly when vec_count < 4.
    directed      = (vec_count[16:2] == '0);
  end

  // Vector k selection: directed corners first, then the LFSR pair.
  always_comb begin
    vec_a   = lfsr_a;
    vec_b   = lfsr_b;
    vec_cin = lfsr_a[0] ^ lfsr_b[WIDTH-1];
    if (directed) begin
      case (vec_count[1:0])
        2'd0: begin vec_a = '0; vec_b = '0; vec_cin = 1'b0; end
        2'd1: begin vec_a = '1; vec_b = WIDTH'(1); vec_cin = 1'b0; end
        2'd2: begin vec_a = '1; vec_b = '1; vec_cin = 1'b1; end
        default: begin
          vec_a   = {1'b0, {(WIDTH-1){1'b1}}};
          vec_b   = WIDTH'(1);
          vec_cin = 1'b0;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    fail       = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        done = (state == ST_DONE);
        fail = (state == ST_FAIL);
        if (start) state_next = ST_DRIVE;
      end
      ST_DRIVE: begin
        busy       = 1'b1;
        state_next = ST_CHECK;
      end
      ST_CHECK: begin
        busy = 1'b1;
        if (!match)        state_next = ST_FAIL;
        else if (last_vec) state_next = ST_DONE;
        else               state_next = ST_DRIVE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand registers, pass counter, error capture and LFSRs.
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_A     <= '0;
      dut_B     <= '0;
      dut_Cin   <= 1'b0;
      vec_count <= '0;
      err_exp   <= '0;
      err_got   <= '0;
      lfsr_a    <= SEED_A;
      lfsr_b    <= SEED_B;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            vec_count <= '0;
            err_exp   <= '0;
            err_got   <= '0;
            lfsr_a    <= SEED_A;
            lfsr_b    <= SEED_B;
          end
        end
        ST_DRIVE: begin
          dut_A   <= vec_a;
          dut_B   <= vec_b;
          dut_Cin <= vec_cin;
        end
        ST_CHECK: begin
          if (match) begin
            vec_count <= vec_count_inc;
            // Only random vectors consume LFSR state, so the first random
            // vector sees the seeds untouched.
            if (!directed) begin
              lfsr_a <= lfsr_step(lfsr_a);
              lfsr_b <= lfsr_step(lfsr_b);
            end
          end else begin
            err_exp <= exp_sum;
            err_got <= got_sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_bist_ctrl.sv
// Directed bench for cla_bist_ctrl driving three controllers (8, 6 and 3
// vectors per run) against a behavioural adder with selectable faults.
module tb_cla_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int   mode = 0;   // 0 correct adder, 1 Sum[0] stuck-at-1, 2 Cout stuck-at-0

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [16:0] model_add(input logic [15:0] a, input logic [15:0] b,
                                             input logic c, input int m);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b} + {16'd0, c};
    if (m == 1) s[0] = 1'b1;
    if (m == 2) s[16] = 1'b0;
    return s;
  endfunction

  // Instance with NUM_VECTORS = 8
  logic [15:0] a8, b8, sum8;
  logic        cin8, cout8, busy8, done8, fail8;
  logic [16:0] vc8, ee8, eg8;
  assign {cout8, sum8} = model_add(a8, b8, cin8, mode);

  cla_bist_ctrl #(.WIDTH(16), .NUM_VECTORS(8), .SEED_A(16'hACE1), .SEED_B(16'h1D2C)) dut8 (
    .clk(clk), .rst(rst), .start(start),
    .dut_A(a8), .dut_B(b8), .dut_Cin(cin8), .dut_Sum(sum8), .dut_Cout(cout8),
    .busy(busy8), .done(done8), .fail(fail8), .vec_count(vc8),
    .err_exp(ee8), .err_got(eg8)
  );

  // Instance with NUM_VECTORS = 6
  logic [15:0] a6, b6, sum6;
  logic        cin6, cout6, busy6, done6, fail6;
  logic [16:0] vc6, ee6, eg6;
  assign {cout6, sum6} = model_add(a6, b6, cin6, mode);

  cla_bist_ctrl #(.WIDTH(16), .NUM_VECTORS(6), .SEED_A(16'hACE1), .SEED_B(16'h1D2C)) dut6 (
    .clk(clk), .rst(rst), .start(start),
    .dut_A(a6), .dut_B(b6), .dut_Cin(cin6), .dut_Sum(sum6), .dut_Cout(cout6),
    .busy(busy6), .done(done6), .fail(fail6), .vec_count(vc6),
    .err_exp(ee6), .err_got(eg6)
  );

  // Instance with NUM_VECTORS = 3 (fewer than the directed set)
  logic [15:0] a3, b3, sum3;
  logic        cin3, cout3, busy3, done3, fail3;
  logic [16:0] vc3, ee3, eg3;
  assign {cout3, sum3} = model_add(a3, b3, cin3, mode);

  cla_bist_ctrl #(.WIDTH(16), .NUM_VECTORS(3), .SEED_A(16'hACE1), .SEED_B(16'h1D2C)) dut3 (
    .clk(clk), .rst(rst), .start(start),
    .dut_A(a3), .dut_B(b3), .dut_Cin(cin3), .dut_Sum(sum3), .dut_Cout(cout3),
    .busy(busy3), .done(done3), .fail(fail3), .vec_count(vc3),
    .err_exp(ee3), .err_got(eg3)
  );

  // Hand-computed vector sequence: 4 directed, then seeds and three LFSR steps
  // (Galois right shift, mask B400).
  logic [15:0] va [8] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h7FFF,
                          16'hACE1, 16'hE270, 16'h7138, 16'h389C};
  logic [15:0] vb [8] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0001,
                          16'h1D2C, 16'h0E96, 16'h074B, 16'hB7A5};
  logic        vcin [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One full run on the correct adder; start is re-pulsed at edge inject
  // (0 = never) to show it is ignored mid-run.
  task automatic run_check(input int inject);
    pulse_start();
    chk("e0_busy", 32'(busy8), 32'd1);
    chk("e0_done", 32'(done8), 32'd0);
    chk("e0_fail", 32'(fail8), 32'd0);
    chk("e0_vc", 32'(vc8), 32'd0);
    chk("e0_eexp", 32'(ee8), 32'd0);
    chk("e0_egot", 32'(eg8), 32'd0);
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      if (e % 2 == 1) begin
        chk($sformatf("v%0d_A", (e + 1) / 2), 32'(a8), 32'(va[(e - 1) / 2]));
        chk($sformatf("v%0d_B", (e + 1) / 2), 32'(b8), 32'(vb[(e - 1) / 2]));
        chk($sformatf("v%0d_Cin", (e + 1) / 2), 32'(cin8), 32'(vcin[(e - 1) / 2]));
        chk($sformatf("v%0d_busy", (e + 1) / 2), 32'(busy8), 32'd1);
        chk($sformatf("v%0d_vc", (e + 1) / 2), 32'(vc8), 32'((e - 1) / 2));
        if (e <= 11) chk($sformatf("n6_v%0d_A", (e + 1) / 2), 32'(a6), 32'(va[(e - 1) / 2]));
      end
      if (e == 5) chk("n3_busy_e5", 32'(busy3), 32'd1);
      if (e == 6) begin
        chk("n3_done", 32'(done3), 32'd1);
        chk("n3_vc", 32'(vc3), 32'd3);
        chk("n3_A_held", 32'(a3), 32'hFFFF);
      end
      if (e == 11) chk("n6_done_early", 32'(done6), 32'd0);
      if (e == 12) begin
        chk("n6_done", 32'(done6), 32'd1);
        chk("n6_fail", 32'(fail6), 32'd0);
        chk("n6_vc", 32'(vc6), 32'd6);
        chk("n6_B_held", 32'(b6), 32'h0E96);
      end
      if (e == 15) chk("n8_done_early", 32'(done8), 32'd0);
      if (e == 16) begin
        chk("n8_done", 32'(done8), 32'd1);
        chk("n8_busy", 32'(busy8), 32'd0);
        chk("n8_fail", 32'(fail8), 32'd0);
        chk("n8_vc", 32'(vc8), 32'd8);
        chk("n8_eexp", 32'(ee8), 32'd0);
        chk("n8_egot", 32'(eg8), 32'd0);
        chk("n8_A_held", 32'(a8), 32'h389C);
        chk("n8_Cin_held", 32'(cin8), 32'd1);
      end
      if (e == inject) start = 1'b1;
      else if (e == inject + 1) start = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_A", 32'(a8), 32'd0);
    chk("rst_Cin", 32'(cin8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_fail", 32'(fail8), 32'd0);
    chk("rst_vc", 32'(vc8), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_hold_busy", 32'(busy8), 32'd0);
    chk("idle_hold_eexp", 32'(ee8), 32'd0);

    // Plain run from IDLE
    run_check(0);
    repeat (3) @(negedge clk);
    chk("done_hold", 32'(done8), 32'd1);
    chk("done_hold_vc", 32'(vc8), 32'd8);

    // Rerun from DONE with a stray start during CHECK (sampled at edge 4)
    run_check(3);

    // Reset asserted at edge 5 of a run
    pulse_start();
    repeat (4) @(negedge clk);
    chk("pre_rst_vc", 32'(vc8), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy8), 32'd0);
    chk("mid_rst_vc", 32'(vc8), 32'd0);
    chk("mid_rst_A", 32'(a8), 32'd0);
    chk("mid_rst_B", 32'(b8), 32'd0);
    chk("mid_rst_done", 32'(done8), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_check(0);

    // Sum[0] stuck-at-1: fails on vector 1
    mode = 1;
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    chk("s0_fail", 32'(fail8), 32'd1);
    chk("s0_busy", 32'(busy8), 32'd0);
    chk("s0_done", 32'(done8), 32'd0);
    chk("s0_vc", 32'(vc8), 32'd0);
    chk("s0_eexp", 32'(ee8), 32'h00000);
    chk("s0_egot", 32'(eg8), 32'h00001);
    repeat (3) @(negedge clk);
    chk("s0_hold_fail", 32'(fail8), 32'd1);
    chk("s0_hold_egot", 32'(eg8), 32'h00001);

    // Cout stuck-at-0: fails on vector 2, restarted straight from FAIL
    mode = 2;
    pulse_start();
    chk("c0_start_fail", 32'(fail8), 32'd0);
    chk("c0_start_egot", 32'(eg8), 32'd0);
    repeat (3) @(negedge clk);
    chk("c0_notyet", 32'(fail8), 32'd0);
    @(negedge clk);
    chk("c0_fail", 32'(fail8), 32'd1);
    chk("c0_vc", 32'(vc8), 32'd1);
    chk("c0_eexp", 32'(ee8), 32'h10000);
    chk("c0_egot", 32'(eg8), 32'h00000);
    chk("c0_A_held", 32'(a8), 32'hFFFF);
    chk("c0_B_held", 32'(b8), 32'h0001);

    // Recovery from FAIL on a good adder
    mode = 0;
    run_check(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_bist_ctrl.md
Name: cla_bist_ctrl

Overview:
- Sequential stimulus generator and response checker that drives a 16-bit adder under test through its A/B/Cin → Sum/Cout interface.
- Used as on-chip/FPGA self-test for the carry-lookahead adder and for any future adder on the same interface.
- Applies 4 directed corner vectors, then LFSR pseudo-random vectors, and compares each response to an internal 17-bit reference sum.
- Stops at the first mismatch and holds the failing data for readout.

Parameters:
- WIDTH, 16, operand width; LFSRs and the reference adder are sized to it.
- NUM_VECTORS, 65535, total vectors per run including directed ones; legal range 1..2^17-1.
- SEED_A, 16'hACE1, reset/restart seed of the A-operand LFSR; must be nonzero.
- SEED_B, 16'h1D2C, reset/restart seed of the B-operand LFSR; must be nonzero.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle run request; honoured only in IDLE, DONE or FAIL.
- dut_A  output  WIDTH  operand A to the adder under test.
- dut_B  output  WIDTH  operand B to the adder under test.
- dut_Cin  output  1  carry-in to the adder under test.
- dut_Sum  input  WIDTH  adder sum; the adder is combinational.
- dut_Cout  input  1  adder carry-out.
- busy  output  1  high in DRIVE and CHECK.
- done  output  1  high in DONE (run passed).
- fail  output  1  high in FAIL (mismatch found).
- vec_count  output  17  number of vectors checked and passed in the current run.
- err_exp  output  WIDTH+1  expected {Cout,Sum} of the failing vector.
- err_got  output  WIDTH+1  received {dut_Cout,dut_Sum} of the failing vector.

Behaviour:
- Reset: all outputs 0 (dut_A/B/Cin=0, busy=done=fail=0, vec_count=0, err_exp=err_got=0); LFSRs load SEED_A/SEED_B; state IDLE.
- FSM states: IDLE, DRIVE, CHECK, DONE, FAIL.
- IDLE/DONE/FAIL + start: clear vec_count, err_exp and err_got; reload the seeds; vector index k=1; go to DRIVE. Without start, hold the current state and all outputs.
- DRIVE (1 cycle): dut_A/B/Cin present vector k, registered; go to CHECK.
- CHECK (1 cycle): operands are held stable. Compute exp = {1'b0,A} + {1'b0,B} + Cin, unsigned, WIDTH+1 bits. Compare exp with {dut_Cout,dut_Sum}:
  - Match: vec_count += 1. If vec_count+1 == NUM_VECTORS, go to DONE; otherwise k += 1 and go to DRIVE.
  - Mismatch: latch err_exp and err_got, leave vec_count unchanged, go to FAIL.
- Directed vectors k=1..4, as (A, B, Cin): (0000,0000,0), (FFFF,0001,0), (FFFF,FFFF,1), (7FFF,0001,0).
- If NUM_VECTORS < 4, only the first NUM_VECTORS directed vectors are run.
- Random vectors k≥5: A=lfsr_a, B=lfsr_b, Cin=lfsr_a[0]^lfsr_b[WIDTH-1].
- LFSRs: 16-bit Galois, right shift, polynomial mask 16'hB400. Each LFSR advances once per passed random vector, in CHECK. The first random vector uses the seeds unmodified.
- Timing: each vector takes exactly 2 cycles. With start sampled at edge 0, done rises after edge 2·NUM_VECTORS.
- Outputs in DONE/FAIL: dut_A/B/Cin hold the last vector; vec_count and err_* hold their values.
- start in DRIVE or CHECK is ignored.
- rst asserted mid-run returns the block to the full reset state on that edge; no partial result survives.
- Cout is compared as an unsigned carry only; signed overflow is not a failure condition.

Test Plan:
- Correct behavioural adder, NUM_VECTORS=8, start pulse at edge 0 → busy high cycles 1..16, done=1 after edge 16, fail=0, vec_count=8, err_exp=err_got=0.
- Adder with Sum[0] stuck-at-1 → fail after edge 2 (vector 1), vec_count=0, err_exp=17'h00000, err_got=17'h00001.
- Adder with Cout forced to 0 → fail on vector 2 (FFFF+0001): vec_count=1, err_exp=17'h10000, err_got=17'h00000.
- Correct adder, NUM_VECTORS=6 → vector 5 is A=ACE1, B=1D2C, Cin=1 with expected 17'h0CA0E; vector 6 uses both LFSRs advanced once; done with vec_count=6.
- Assert rst at edge 5 of a run, then start again → the run restarts from directed vector 1 with the seeds reloaded, and results match a run with no reset.
- start pulsed during CHECK, and a second start after DONE → the first is ignored; the second clears DONE/vec_count and reruns the identical vector sequence.
